// File: rtl/wb_dma_copy_pkg.sv
// Shared types and constants for the single-channel Wishbone block copy engine.
package wb_dma_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] SEL_ALL    = 4'hF;

  // Word-aligned byte address of element idx; wraps modulo 2^32.
  function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [31:0] idx);
    return (base & ~32'h3) + idx * WORD_BYTES;
  endfunction

endpackage

// File: rtl/wb_dma_copy.sv
// Copies len 32-bit words src->dst, one read then one write per word; 4 cycles/word with a 1-cycle-ack slave.
// Backpressure: wb_stall_i holds the REQ state with all outputs frozen; stb drops once accepted until ack/err.
module wb_dma_copy
  import wb_dma_copy_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [31:0]          src_adr_i,
  input  logic [31:0]          dst_adr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_stall_i
);

  state_e               state;
  logic [31:0]          src_q;
  logic [31:0]          dst_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] cnt_nxt;

  assign cnt_nxt = cnt + 1'b1;

  // All bus outputs are registered and updated on the transition into each state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      cnt      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      error_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            src_q   <= src_adr_i;
            dst_q   <= dst_adr_i;
            len_q   <= len_i;
            cnt     <= '0;
            error_o <= 1'b0;
            busy_o  <= 1'b1;
            if (len_i == '0) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_sel_o <= SEL_ALL;
              wb_adr_o <= word_adr(src_adr_i, 32'd0);
              state    <= ST_RD_REQ;
            end
          end
        end

        ST_RD_REQ: begin
          if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (wb_err_i) begin
            error_o  <= 1'b1;
            done_o   <= 1'b1;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            state    <= ST_DONE;
          end else if (wb_ack_i) begin
            wb_dat_o <= wb_dat_i;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= word_adr(dst_q, 32'(cnt));
            state    <= ST_WR_REQ;
          end
        end

        ST_WR_REQ: begin
          if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= ST_WR_WAIT;
          end
        end

        ST_WR_WAIT: begin
          if (wb_err_i) begin
            error_o  <= 1'b1;
            done_o   <= 1'b1;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            state    <= ST_DONE;
          end else if (wb_ack_i) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              done_o   <= 1'b1;
              wb_cyc_o <= 1'b0;
              wb_we_o  <= 1'b0;
              wb_sel_o <= '0;
              state    <= ST_DONE;
            end else begin
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_adr_o <= word_adr(src_q, 32'(cnt_nxt));
              state    <= ST_RD_REQ;
            end
          end
        end

        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
